// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - shared constants and state type for the jump-resolution unit
package jump_pkg;

  localparam int PC_W  = 32;
  localparam int IMM_W = 26;

  localparam logic [3:0] PATH_J   = 4'd6;
  localparam logic [3:0] PATH_JAL = 4'd7;
  localparam logic [3:0] PATH_JR  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/jump_target_calc.sv
// rtl/jump_target_calc.sv - combinational next-PC selection (JAL handled only with JUMP_LINK_EN)
module jump_target_calc #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 26
) (
  input  logic             jump,
  input  logic [3:0]       path_index,
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] addr,
  input  logic [PC_W-1:0]  reg_addr,
  output logic [PC_W-1:0]  target,
  output logic             is_link
);
  import jump_pkg::*;

  // Fall-through unless a recognised jump path is flagged as a jump
  always_comb begin
    target  = pc + PC_W'(1);
    is_link = 1'b0;
    if (jump) begin
      case (path_index)
        PATH_J:  target = {pc[PC_W-1:IMM_W], addr};
`ifdef JUMP_LINK_EN
        PATH_JAL: begin
          target  = {pc[PC_W-1:IMM_W], addr};
          is_link = 1'b1;
        end
`endif
        PATH_JR: target = reg_addr;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jump_module.sv
// rtl/jump_module.sv - jump-resolution FSM and output registers (link ports with JUMP_LINK_EN)
module jump_module #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             jump,
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] addr,
  input  logic [3:0]       path_index,
  input  logic [PC_W-1:0]  reg_addr,
`ifdef JUMP_LINK_EN
  output logic             link_we,
  output logic [PC_W-1:0]  link_data,
`endif
  output logic [PC_W-1:0]  pc_out,
  output logic             jump_done
);
  import jump_pkg::*;

  state_t            state, state_n;
  logic              load;
  logic [PC_W-1:0]   target;
  logic              link_flag;
  logic [PC_W-1:0]   pc_out_q;

  jump_target_calc #(.PC_W(PC_W), .IMM_W(IMM_W)) u_calc (
    .jump       (jump),
    .path_index (path_index),
    .pc         (pc),
    .addr       (addr),
    .reg_addr   (reg_addr),
    .target     (target),
    .is_link    (link_flag)
  );

  // State register; reset wins over en
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // One DONE cycle per en assertion; HOLD parks until en drops
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en) state_n = DONE;
      DONE:    state_n = en ? HOLD : IDLE;
      HOLD:    if (!en) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign load = (state == IDLE) && en;

  // Result captured only when an operation starts; held everywhere else
  always_ff @(posedge clk) begin
    if (rst)       pc_out_q <= '0;
    else if (load) pc_out_q <= target;
  end

  assign pc_out    = pc_out_q;
  assign jump_done = (state == DONE);

`ifdef JUMP_LINK_EN
  logic            link_we_q;
  logic [PC_W-1:0] link_data_q;

  // Link write strobe lives only in the DONE cycle of a JAL
  always_ff @(posedge clk) begin
    if (rst) begin
      link_we_q   <= 1'b0;
      link_data_q <= '0;
    end else begin
      link_we_q <= load && link_flag;
      if (load && link_flag) link_data_q <= pc + PC_W'(1);
    end
  end

  assign link_we   = link_we_q;
  assign link_data = link_data_q;
`else
  logic unused_link;
  assign unused_link = link_flag;
`endif

endmodule

// File: tb/tb_jump_module.sv
// tb/tb_jump_module.sv - randomized self-checking bench for jump_module (honours JUMP_LINK_EN)
module tb_jump_module;

  logic        clk = 1'b0;
  logic        rst, en, jump;
  logic [31:0] pc, reg_addr;
  logic [25:0] addr;
  logic [3:0]  path_index;
  logic [31:0] pc_out;
  logic        jump_done;
`ifdef JUMP_LINK_EN
  logic        link_we;
  logic [31:0] link_data;
`endif

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference: outputs of the most recent started operation plus whether
  // the current en-high run has already produced its operation.
  logic [31:0] m_pc, m_ldata;
  logic        m_done, m_lwe, m_used;

  jump_module dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .jump       (jump),
    .pc         (pc),
    .addr       (addr),
    .path_index (path_index),
    .reg_addr   (reg_addr),
`ifdef JUMP_LINK_EN
    .link_we    (link_we),
    .link_data  (link_data),
`endif
    .pc_out     (pc_out),
    .jump_done  (jump_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic j, input logic [3:0] p,
                                             input logic [31:0] cur, input logic [25:0] a,
                                             input logic [31:0] r);
    logic [31:0] upper;
    upper = cur & 32'hFC00_0000;
    if (j && p == 4'd6) return upper | {6'd0, a};
`ifdef JUMP_LINK_EN
    if (j && p == 4'd7) return upper | {6'd0, a};
`endif
    if (j && p == 4'd8) return r;
    return cur + 32'd1;
  endfunction

  // Apply inputs on the falling edge, let one rising edge pass, check on the next falling edge
  task automatic step(input logic r, input logic e, input logic j, input logic [31:0] p,
                      input logic [25:0] a, input logic [3:0] pi, input logic [31:0] ra);
    rst = r; en = e; jump = j; pc = p; addr = a; path_index = pi; reg_addr = ra;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_done = 0; m_lwe = 0; m_ldata = 0; m_used = 0;
    end else if (e && !m_used) begin
      m_pc   = ref_target(j, pi, p, a, ra);
      m_done = 1;
      m_used = 1;
`ifdef JUMP_LINK_EN
      m_lwe = j && pi == 4'd7;
      if (m_lwe) m_ldata = p + 32'd1;
`endif
    end else begin
      m_done = 0;
      m_lwe  = 0;
      if (!e) m_used = 0;
    end
    @(negedge clk);
    check("pc_out", pc_out, m_pc);
    check("jump_done", {31'd0, jump_done}, {31'd0, m_done});
`ifdef JUMP_LINK_EN
    check("link_we", {31'd0, link_we}, {31'd0, m_lwe});
    check("link_data", link_data, m_ldata);
`endif
    if (jump_done) pulses++;
  endtask

  initial begin
    logic [3:0]  pi;
    logic [31:0] p;
    rst = 1; en = 0; jump = 0; pc = 0; addr = 0; path_index = 0; reg_addr = 0;
    @(negedge clk);

    // Reset for two cycles
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h55, 26'h7, 4'd6, 32'h9);
    check("reset_pc", pc_out, 32'h0);
    check("reset_done", {31'd0, jump_done}, 32'h0);

    // J: en low 5 cycles, then high 20 -> single pulse, pc_out 5 held
    pulses = 0;
    for (int i = 0; i < 5; i++)  step(0, 0, 1, 32'd3, 26'd5, 4'd6, 32'd4);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 32'd3, 26'd5, 4'd6, 32'd4);
    check("j_pulses", pulses, 1);
    check("j_pc", pc_out, 32'd5);

    // JR and its fall-through twin
    step(0, 0, 1, 32'h10, 26'd0, 4'd8, 32'h400);
    step(0, 1, 1, 32'h10, 26'd0, 4'd8, 32'h400);
    check("jr_pc", pc_out, 32'h400);
    step(0, 0, 0, 32'h10, 26'd0, 4'd8, 32'h400);
    step(0, 1, 0, 32'h10, 26'd0, 4'd8, 32'h400);
    check("jr_nojump_pc", pc_out, 32'h11);

    // Upper PC bits kept, then sequential wrap
    step(0, 0, 1, 32'hFC00_0003, 26'h3FF_FFFF, 4'd6, 32'd0);
    step(0, 1, 1, 32'hFC00_0003, 26'h3FF_FFFF, 4'd6, 32'd0);
    check("j_upper_pc", pc_out, 32'hFFFF_FFFF);
    step(0, 0, 1, 32'hFFFF_FFFF, 26'd0, 4'd2, 32'd0);
    step(0, 1, 1, 32'hFFFF_FFFF, 26'd0, 4'd2, 32'd0);
    check("wrap_pc", pc_out, 32'h0);

    // JAL
    step(0, 0, 1, 32'd9, 26'h20, 4'd7, 32'd0);
    step(0, 1, 1, 32'd9, 26'h20, 4'd7, 32'd0);
`ifdef JUMP_LINK_EN
    check("jal_pc", pc_out, 32'h20);
    check("jal_link_we", {31'd0, link_we}, 32'd1);
    check("jal_link_data", link_data, 32'd10);
    step(0, 1, 1, 32'd9, 26'h20, 4'd7, 32'd0);
    check("jal_link_we_drop", {31'd0, link_we}, 32'd0);
`else
    check("jal_pc", pc_out, 32'd10);
`endif

    // Reset while in HOLD with en high, then release with en still high
    step(0, 1, 1, 32'd9, 26'h20, 4'd7, 32'd0);
    step(1, 1, 1, 32'd9, 26'h20, 4'd6, 32'd0);
    check("hold_reset_pc", pc_out, 32'h0);
    check("hold_reset_done", {31'd0, jump_done}, 32'h0);
    step(0, 1, 1, 32'h40, 26'h33, 4'd6, 32'd0);
    check("post_reset_done", {31'd0, jump_done}, 32'd1);
    check("post_reset_pc", pc_out, 32'h33);

    // Randomized traffic; inputs also change while an operation is in DONE/HOLD
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: pi = 4'd6;
        1: pi = 4'd7;
        2: pi = 4'd8;
        default: pi = 4'($urandom_range(0, 15));
      endcase
      p = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 4) != 0,
           p, 26'($urandom), pi, 32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
